pixel_line_fifo: RTL and testbench
==================================

# pixel_line_fifo

Parametrised pixel line FIFO for the VGA pipeline. It buffers palette-index pixels between the sprite/frame renderer (writer) and the scan-out path (reader). Unlike the fixed 640×4 line RAM, it adds push/pop pointer management, full/empty/level status, and error flags. It also provides a mark/rewind facility so scan-out can replay a retained line; this is used for 2× vertical scaling of 320×240 content.

## Interface
- WIDTH, 4, pixel word width (palette index bits)
- DEPTH, 640, entries; any value ≥ 2, not required to be a power of two
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- push  in  1  write data_In this cycle
- data_In  in  WIDTH  write data
- pop  in  1  read request
- data_Out  out  WIDTH  read data, registered
- out_valid  out  1  data_Out holds a newly popped word this cycle
- mark  in  1  start retaining entries from the current read pointer
- rewind  in  1  return the read pointer to the mark
- release  in  1  drop the mark; retained entries become free
- clr_err  in  1  clear the sticky error flags
- full  out  1  occupancy == DEPTH
- empty  out  1  level == 0
- level  out  AW+1  readable entries (rd_ptr to wr_ptr)
- overflow  out  1  sticky; a push was dropped
- underflow  out  1  sticky; a pop was ignored

## Operation
- State:
  - wr_ptr, rd_ptr and mark_ptr, each 0..DEPTH-1; increments wrap explicitly from DEPTH-1 to 0.
  - level and occupancy, each 0..DEPTH.
  - mark_valid.
- occupancy counts entries from mark_ptr to wr_ptr when mark_valid is set; otherwise it equals level.
- Accepted push (push && !full):
  - mem[wr_ptr] <= data_In; wr_ptr advances.
  - level and occupancy each increment.
- Accepted pop (pop && !empty && !rewind):
  - data_Out <= mem[rd_ptr] and out_valid <= 1 on the next edge; rd_ptr advances.
  - level decrements.
  - occupancy decrements only when !mark_valid.
- Push and pop accepted in the same cycle: level is unchanged.
  - occupancy is unchanged when !mark_valid.
  - occupancy increments when mark_valid.
- mark, when not overridden by rewind:
  - mark_ptr <= rd_ptr, using the pre-pop value, so a word popped in the same cycle is the first retained word.
  - mark_valid <= 1.
  - A re-mark while mark_valid moves the mark, and occupancy recomputes to match.
- rewind with mark_valid:
  - rd_ptr <= mark_ptr; level <= occupancy, including any same-cycle accepted push.
  - mark_valid stays set, so the line can be replayed repeatedly.
  - rewind without mark_valid has no effect.
- release: mark_valid <= 0; occupancy <= level.
- Priority when control inputs coincide: rewind > release > mark.
  - Any pop coinciding with rewind is ignored; out_valid <= 0; no underflow.
- Dropped operations and error flags:
  - Push while full is dropped and sets overflow, even if a pop occurs the same cycle.
  - Pop while empty (including push+pop on an empty FIFO; there is no read-through) is ignored, sets underflow, and gives out_valid <= 0.
  - overflow and underflow clear only on clr_err or Reset; a set event in the same cycle as clr_err wins.
- data_Out holds its last value when out_valid is 0.
- Memory is inferred as synchronous block RAM and is not reset.

## Timing
- Reset values: data_Out 0, out_valid 0, full 0, empty 1, level 0, overflow 0, underflow 0.
  - All pointers, occupancy and mark_valid are 0.
  - RAM contents are undefined.
- Reset asserted mid-operation discards all buffered data and the mark at that edge; inputs are ignored while Reset is high.
- Status outputs are registered and reflect operations accepted at the previous edge.
- Latency for push in cycle N:
  - empty falls and level updates after edge N.
  - The earliest accepted pop is in cycle N+1.
  - data_Out and out_valid are valid in cycle N+2.
- Pop-to-data latency is one cycle; back-to-back pops give one word per cycle.
- After rewind in cycle N, a pop in cycle N+1 returns mem[mark_ptr] in cycle N+2.
- Wrap: a pointer at DEPTH-1 moves to 0 with no gap or extra cycle.

## Test plan
- Reset, then push values 0..9 in cycles 1–10, then pop 10 times back-to-back.
  - Required: data_Out = 0..9 in consecutive cycles, out_valid high for 10 cycles, and level returning 10→0 with empty reasserted.
- With DEPTH=640, fill completely.
  - Required: full=1 and level=640.
  - An 641st push is dropped and sets overflow=1; a later pop returns the original first word.
  - clr_err clears overflow.
- Pop on empty, then push+pop in the same cycle on empty.
  - Required: underflow=1, out_valid=0 both times, and level=1 afterwards.
- Mark at rd_ptr, pop 320 words, rewind, pop 320 words.
  - Required: the identical 320-word sequence twice.
  - While marked, full asserts at occupancy 640 even though level < 640.
  - release frees the 320 retained slots.
- With DEPTH=5, run 12 push/pop pairs.
  - Required: correct order across pointer wrap at 4→0, and level stays at 1.
- Assert Reset mid-stream with level=7 and mark_valid=1.
  - Required next cycle: empty=1, level=0, out_valid=0, and a rewind has no effect.

Source files
------------

// File: rtl/pixel_line_fifo.sv
// Pixel line FIFO between the renderer and scan-out, with a mark/rewind window
// so a retained line can be replayed (2x vertical scaling of 320x240 content).
module pixel_line_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 640,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             push,
   input  logic [WIDTH-1:0] data_In,
   input  logic             pop,
   output logic [WIDTH-1:0] data_Out,
   output logic             out_valid,
   input  logic             mark,
   input  logic             rewind,
   input  logic             release_mark,
   input  logic             clr_err,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [AW-1:0]    mark_ptr_reg, mark_ptr_next;
   logic [AW:0]      level_reg, level_next;
   logic [AW:0]      occ_reg, occ_next;
   logic [AW:0]      level_after, push_w, pop_w;
   logic             mark_valid_reg, mark_valid_next;
   logic             full_reg, empty_reg;
   logic             overflow_reg, underflow_reg;
   logic             out_valid_reg;
   logic [WIDTH-1:0] data_out_reg;
   logic             push_ok, pop_ok, rewind_hit;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      push_ok         = push && !full_reg;
      pop_ok          = pop && !empty_reg && !rewind;
      rewind_hit      = rewind && mark_valid_reg;
      push_w          = {{AW{1'b0}}, push_ok};
      pop_w           = {{AW{1'b0}}, pop_ok};
      level_after     = level_reg + push_w - pop_w;
      wr_ptr_next     = push_ok ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
      rd_ptr_next     = pop_ok ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
      mark_ptr_next   = mark_ptr_reg;
      mark_valid_next = mark_valid_reg;
      level_next      = level_after;
      // While marked, pops do not free space: occupancy only grows with pushes.
      occ_next        = mark_valid_reg ? occ_reg + push_w : level_after;
      if (rewind_hit) begin
         rd_ptr_next = mark_ptr_reg;
         level_next  = occ_reg + push_w;
         occ_next    = occ_reg + push_w;
      end else if (!rewind && release_mark) begin
         mark_valid_next = 1'b0;
         occ_next        = level_after;
      end else if (!rewind && mark) begin
         // Pre-pop read pointer: a word popped this cycle is the first retained.
         mark_ptr_next   = rd_ptr_reg;
         mark_valid_next = 1'b1;
         occ_next        = level_reg + push_w;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset && push_ok) begin
         mem[wr_ptr_reg] <= data_In;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         mark_ptr_reg   <= '0;
         level_reg      <= '0;
         occ_reg        <= '0;
         mark_valid_reg <= 1'b0;
         full_reg       <= 1'b0;
         empty_reg      <= 1'b1;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
         out_valid_reg  <= 1'b0;
         data_out_reg   <= '0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         mark_ptr_reg   <= mark_ptr_next;
         level_reg      <= level_next;
         occ_reg        <= occ_next;
         mark_valid_reg <= mark_valid_next;
         full_reg       <= (occ_next == DEPTH_L);
         empty_reg      <= (level_next == '0);
         out_valid_reg  <= pop_ok;
         if (pop_ok) begin
            data_out_reg <= mem[rd_ptr_reg];
         end
         if (push && full_reg) begin
            overflow_reg <= 1'b1;
         end else if (clr_err) begin
            overflow_reg <= 1'b0;
         end
         if (pop && empty_reg && !rewind) begin
            underflow_reg <= 1'b1;
         end else if (clr_err) begin
            underflow_reg <= 1'b0;
         end
      end
   end

   assign data_Out  = data_out_reg;
   assign out_valid = out_valid_reg;
   assign full      = full_reg;
   assign empty     = empty_reg;
   assign level     = level_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_pixel_line_fifo.sv
// Scoreboard bench for pixel_line_fifo: a 640-deep instance for the main
// scenarios and a 5-deep instance for pointer wrap.
module tb_pixel_line_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0, pop = 1'b0, mark = 1'b0, rewind = 1'b0, rel = 1'b0, clr_err = 1'b0;
   logic [3:0]  data_in = '0;
   logic [3:0]  data_out;
   logic        out_valid, full, empty, overflow, underflow;
   logic [10:0] level;

   logic        push5 = 1'b0, pop5 = 1'b0;
   logic [3:0]  data5_in = '0;
   logic [3:0]  data5_out;
   logic        out5_valid, full5, empty5, overflow5, underflow5;
   logic [3:0]  level5;

   int vectors = 0;
   int miscompares = 0;
   logic [3:0] sb[$];
   logic [3:0] sb5[$];
   logic [3:0] line_ref [640];
   logic [3:0] exp_w;

   always #5 clk = ~clk;

   pixel_line_fifo #(.WIDTH(4), .DEPTH(640)) dut (
      .Clk(clk), .Reset(rst), .push(push), .data_In(data_in), .pop(pop),
      .data_Out(data_out), .out_valid(out_valid), .mark(mark), .rewind(rewind),
      .release_mark(rel), .clr_err(clr_err), .full(full), .empty(empty),
      .level(level), .overflow(overflow), .underflow(underflow)
   );

   pixel_line_fifo #(.WIDTH(4), .DEPTH(5)) dut5 (
      .Clk(clk), .Reset(rst), .push(push5), .data_In(data5_in), .pop(pop5),
      .data_Out(data5_out), .out_valid(out5_valid), .mark(1'b0), .rewind(1'b0),
      .release_mark(1'b0), .clr_err(1'b0), .full(full5), .empty(empty5),
      .level(level5), .overflow(overflow5), .underflow(underflow5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if ({data_out, out_valid, full, empty, overflow, underflow} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_flags got dout=%0d ov=%b full=%b empty=%b ovf=%b udf=%b want 0 0 0 1 0 0",
                  data_out, out_valid, full, empty, overflow, underflow);
      end
      vectors++;
      if (level !== 11'd0 || empty5 !== 1'b1 || level5 !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_level got %0d/%0d empty5=%b want 0/0 1", level, level5, empty5);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      for (int i = 0; i < 10; i++) begin
         push = 1'b1; data_in = 4'(i); sb.push_back(4'(i));
         tick();
         if (i == 0) begin
            vectors++;
            if (empty !== 1'b0 || level !== 11'd1) begin
               miscompares++;
               $display("FAIL basic_first_push got empty=%b level=%0d want 0 1", empty, level);
            end
         end
      end
      push = 1'b0;
      vectors++;
      if (level !== 11'd10) begin
         miscompares++;
         $display("FAIL basic_level10 got %0d want 10", level);
      end
      pop = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         exp_w = (sb.size() > 0) ? sb.pop_front() : 4'hx;
         vectors++;
         if (out_valid !== 1'b1 || data_out !== exp_w || level !== 11'(9 - i)) begin
            miscompares++;
            $display("FAIL basic_pop%0d got v=%b d=%0d lvl=%0d want 1 %0d %0d",
                     i, out_valid, data_out, level, exp_w, 9 - i);
         end
         $display("basic pop %0d data=%0d level=%0d", i, data_out, level);
      end
      pop = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b0 || empty !== 1'b1 || data_out !== 4'd9) begin
         miscompares++;
         $display("FAIL basic_drained got v=%b empty=%b d=%0d want 0 1 9", out_valid, empty, data_out);
      end
   endtask

   task automatic test_full();
      logic [3:0] first_w;
      for (int i = 0; i < 640; i++) begin
         push = 1'b1; data_in = 4'($urandom_range(0, 15)); sb.push_back(data_in);
         if (i == 0) first_w = data_in;
         tick();
      end
      vectors++;
      if (full !== 1'b1 || level !== 11'd640 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL full_fill got full=%b level=%0d ovf=%b want 1 640 0", full, level, overflow);
      end
      data_in = ~first_w;
      tick();
      push = 1'b0;
      vectors++;
      if (overflow !== 1'b1 || level !== 11'd640) begin
         miscompares++;
         $display("FAIL full_overflow got ovf=%b level=%0d want 1 640", overflow, level);
      end
      pop = 1'b1;
      for (int i = 0; i < 640; i++) begin
         tick();
         if (i == 0) begin
            clr_err = 1'b1;
            vectors++;
            if (data_out !== first_w) begin
               miscompares++;
               $display("FAIL full_first_word got %0d want %0d", data_out, first_w);
            end
         end else if (i == 1) begin
            clr_err = 1'b0;
            vectors++;
            if (overflow !== 1'b0) begin
               miscompares++;
               $display("FAIL full_clr_err got ovf=%b want 0", overflow);
            end
         end
         exp_w = (sb.size() > 0) ? sb.pop_front() : 4'hx;
         vectors++;
         if (out_valid !== 1'b1 || data_out !== exp_w) begin
            miscompares++;
            $display("FAIL full_drain%0d got v=%b d=%0d want 1 %0d", i, out_valid, data_out, exp_w);
         end
      end
      pop = 1'b0;
      tick();
      vectors++;
      if (empty !== 1'b1 || full !== 1'b0) begin
         miscompares++;
         $display("FAIL full_empty got empty=%b full=%b want 1 0", empty, full);
      end
      $display("test_full done");
   endtask

   task automatic test_underflow();
      pop = 1'b1;
      tick();
      pop = 1'b0;
      vectors++;
      if (underflow !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL uf_pop_empty got udf=%b v=%b want 1 0", underflow, out_valid);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      vectors++;
      if (underflow !== 1'b0) begin
         miscompares++;
         $display("FAIL uf_clear got %b want 0", underflow);
      end
      push = 1'b1; pop = 1'b1; data_in = 4'd7;
      tick();
      push = 1'b0;
      vectors++;
      if (underflow !== 1'b1 || out_valid !== 1'b0 || level !== 11'd1) begin
         miscompares++;
         $display("FAIL uf_push_pop_empty got udf=%b v=%b lvl=%0d want 1 0 1", underflow, out_valid, level);
      end
      clr_err = 1'b1;
      tick();
      vectors++;
      if (underflow !== 1'b0 || out_valid !== 1'b1 || data_out !== 4'd7) begin
         miscompares++;
         $display("FAIL uf_read_back got udf=%b v=%b d=%0d want 0 1 7", underflow, out_valid, data_out);
      end
      tick();
      vectors++;
      if (underflow !== 1'b1) begin
         miscompares++;
         $display("FAIL uf_set_beats_clear got %b want 1", underflow);
      end
      pop = 1'b0;
      tick();
      clr_err = 1'b0;
      vectors++;
      if (underflow !== 1'b0 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL uf_final got udf=%b empty=%b want 0 1", underflow, empty);
      end
      $display("test_underflow done");
   endtask

   task automatic test_mark_rewind();
      for (int i = 0; i < 640; i++) line_ref[i] = 4'($urandom_range(0, 15));
      push = 1'b1;
      for (int i = 0; i < 400; i++) begin
         data_in = line_ref[i];
         tick();
      end
      push = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         pop = 1'b1;
         for (int i = 0; i < 320; i++) begin
            mark = (pass == 0 && i == 0);
            tick();
            vectors++;
            if (out_valid !== 1'b1 || data_out !== line_ref[i]) begin
               miscompares++;
               $display("FAIL mark_pass%0d_word%0d got v=%b d=%0d want 1 %0d",
                        pass, i, out_valid, data_out, line_ref[i]);
            end
         end
         pop = 1'b0; mark = 1'b0;
         if (pass == 0) begin
            push = 1'b1;
            for (int i = 400; i < 640; i++) begin
               data_in = line_ref[i];
               tick();
            end
            push = 1'b0;
            vectors++;
            if (full !== 1'b1 || level !== 11'd320) begin
               miscompares++;
               $display("FAIL mark_full_occ got full=%b level=%0d want 1 320", full, level);
            end
            rewind = 1'b1;
            tick();
            rewind = 1'b0;
            vectors++;
            if (level !== 11'd640 || out_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL mark_rewind_level got lvl=%0d v=%b want 640 0", level, out_valid);
            end
         end
      end
      rel = 1'b1;
      tick();
      rel = 1'b0;
      vectors++;
      if (full !== 1'b0 || level !== 11'd320) begin
         miscompares++;
         $display("FAIL mark_release got full=%b level=%0d want 0 320", full, level);
      end
      pop = 1'b1;
      for (int i = 320; i < 640; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || data_out !== line_ref[i]) begin
            miscompares++;
            $display("FAIL mark_tail%0d got v=%b d=%0d want 1 %0d", i, out_valid, data_out, line_ref[i]);
         end
      end
      pop = 1'b0;
      tick();
      vectors++;
      if (empty !== 1'b1) begin
         miscompares++;
         $display("FAIL mark_empty got %b want 1", empty);
      end
      $display("test_mark_rewind done");
   endtask

   task automatic test_wrap();
      push5 = 1'b1; data5_in = 4'd1; sb5.push_back(4'd1);
      tick();
      pop5 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         data5_in = 4'(i + 2); sb5.push_back(data5_in);
         tick();
         exp_w = (sb5.size() > 0) ? sb5.pop_front() : 4'hx;
         vectors++;
         if (out5_valid !== 1'b1 || data5_out !== exp_w || level5 !== 4'd1) begin
            miscompares++;
            $display("FAIL wrap_pair%0d got v=%b d=%0d lvl=%0d want 1 %0d 1",
                     i, out5_valid, data5_out, level5, exp_w);
         end
         $display("wrap pair %0d data=%0d level=%0d", i, data5_out, level5);
      end
      push5 = 1'b0;
      tick();
      pop5 = 1'b0;
      exp_w = (sb5.size() > 0) ? sb5.pop_front() : 4'hx;
      vectors++;
      if (data5_out !== exp_w || empty5 !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_last got d=%0d empty=%b want %0d 1", data5_out, empty5, exp_w);
      end
   endtask

   task automatic test_reset_mid();
      push = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in = 4'(i + 3);
         tick();
      end
      push = 1'b0; pop = 1'b1; mark = 1'b1;
      tick();
      mark = 1'b0;
      tick();
      tick();
      pop = 1'b0;
      vectors++;
      if (level !== 11'd7) begin
         miscompares++;
         $display("FAIL rstmid_setup got level=%0d want 7", level);
      end
      rst = 1'b1; push = 1'b1;
      tick();
      rst = 1'b0; push = 1'b0;
      vectors++;
      if (empty !== 1'b1 || level !== 11'd0 || out_valid !== 1'b0 || data_out !== 4'd0) begin
         miscompares++;
         $display("FAIL rstmid_state got empty=%b lvl=%0d v=%b d=%0d want 1 0 0 0",
                  empty, level, out_valid, data_out);
      end
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      vectors++;
      if (empty !== 1'b1 || level !== 11'd0 || full !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_rewind got empty=%b lvl=%0d full=%b want 1 0 0", empty, level, full);
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_underflow();
      test_mark_rewind();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
